// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates the unified memory between fetch (F) and
//               load/store (D); registered one-cycle read response.
// Revision    : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ARB_MODE = 0,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_f_req,
    input  logic [31:0]      i_f_addr,
    output logic             o_f_gnt,
    output logic             o_f_rvalid,
    output logic [31:0]      o_f_rdata,
    input  logic             i_d_req,
    input  logic             i_d_we,
    input  logic [31:0]      i_d_addr,
    input  logic [31:0]      i_d_wdata,
    output logic             o_d_gnt,
    output logic             o_d_rvalid,
    output logic [31:0]      o_d_rdata,
    output logic [31:0]      o_mem_addr,
    output logic             o_mem_we,
    output logic [31:0]      o_mem_wdata,
    input  logic [31:0]      i_mem_rdata,
    output logic [CNT_W-1:0] o_conflict_cnt
);

    localparam int         c_WAIT_W   = 4;
    localparam logic [3:0] c_MAX_WAIT = c_WAIT_W'(MAX_WAIT);

    logic             r_rr_d_first;
    logic [3:0]       r_f_wait;
    logic             w_conflict;
    logic             w_f_wins;
    logic             w_f_gnt;
    logic             w_d_gnt;

    assign w_conflict = i_f_req & i_d_req;

    // Round-robin follows the pointer; fixed priority lets F through only once starved.
    assign w_f_wins = (ARB_MODE == 0) ? ~r_rr_d_first : (r_f_wait == c_MAX_WAIT);

    always_comb begin
        w_f_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (i_rst_n) begin
            if (w_conflict) begin
                w_f_gnt = w_f_wins;
                w_d_gnt = ~w_f_wins;
            end else begin
                w_f_gnt = i_f_req;
                w_d_gnt = i_d_req;
            end
        end
    end

    assign o_f_gnt     = w_f_gnt;
    assign o_d_gnt     = w_d_gnt;
    assign o_mem_addr  = w_f_gnt ? i_f_addr : (w_d_gnt ? i_d_addr : 32'h0);
    assign o_mem_we    = i_d_we & w_d_gnt;
    assign o_mem_wdata = w_d_gnt ? i_d_wdata : 32'h0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_f_rvalid     <= 1'b0;
            o_d_rvalid     <= 1'b0;
            o_f_rdata      <= 32'h0;
            o_d_rdata      <= 32'h0;
            o_conflict_cnt <= '0;
            r_rr_d_first   <= 1'b1;
            r_f_wait       <= '0;
        end else begin
            o_f_rvalid <= w_f_gnt;
            o_d_rvalid <= w_d_gnt;
            // Memory updates after this edge, so a D write returns the old word.
            if (w_f_gnt) begin
                o_f_rdata <= i_mem_rdata;
            end
            if (w_d_gnt) begin
                o_d_rdata <= i_mem_rdata;
            end
            if (w_conflict) begin
                r_rr_d_first <= ~r_rr_d_first;
            end
            if (!i_f_req || w_f_gnt) begin
                r_f_wait <= '0;
            end else if (r_f_wait != c_MAX_WAIT) begin
                r_f_wait <= r_f_wait + 4'd1;
            end
            if (w_conflict && (o_conflict_cnt != {CNT_W{1'b1}})) begin
                o_conflict_cnt <= o_conflict_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed scoreboard bench; unit 0 round-robin, unit 1 fixed
//               priority (MAX_WAIT=2, CNT_W=2).
// Revision    : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n   [2];
    logic        f_req   [2];
    logic [31:0] f_addr  [2];
    logic        d_req   [2];
    logic        d_we    [2];
    logic [31:0] d_addr  [2];
    logic [31:0] d_wdata [2];
    logic        f_gnt   [2];
    logic        f_rvalid[2];
    logic [31:0] f_rdata [2];
    logic        d_gnt   [2];
    logic        d_rvalid[2];
    logic [31:0] d_rdata [2];
    logic [31:0] mem_addr[2];
    logic        mem_we  [2];
    logic [31:0] mem_wdata[2];
    logic [31:0] mem_rdata0;
    logic [31:0] mem_rdata1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    logic [31:0] mem0 [512];
    logic [31:0] ref0 [512];
    logic [31:0] qf0[$], qd0[$], qf1[$], qd1[$];
    int          cnt_exp [2];
    int          cnt_max [2];
    int          ntests = 0;
    int          nfail  = 0;

    mem_port_arbiter #(.ARB_MODE(0), .MAX_WAIT(4), .CNT_W(16)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n[0]),
        .i_f_req(f_req[0]), .i_f_addr(f_addr[0]), .o_f_gnt(f_gnt[0]),
        .o_f_rvalid(f_rvalid[0]), .o_f_rdata(f_rdata[0]),
        .i_d_req(d_req[0]), .i_d_we(d_we[0]), .i_d_addr(d_addr[0]),
        .i_d_wdata(d_wdata[0]), .o_d_gnt(d_gnt[0]),
        .o_d_rvalid(d_rvalid[0]), .o_d_rdata(d_rdata[0]),
        .o_mem_addr(mem_addr[0]), .o_mem_we(mem_we[0]), .o_mem_wdata(mem_wdata[0]),
        .i_mem_rdata(mem_rdata0), .o_conflict_cnt(cnt0)
    );

    mem_port_arbiter #(.ARB_MODE(1), .MAX_WAIT(2), .CNT_W(2)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n[1]),
        .i_f_req(f_req[1]), .i_f_addr(f_addr[1]), .o_f_gnt(f_gnt[1]),
        .o_f_rvalid(f_rvalid[1]), .o_f_rdata(f_rdata[1]),
        .i_d_req(d_req[1]), .i_d_we(d_we[1]), .i_d_addr(d_addr[1]),
        .i_d_wdata(d_wdata[1]), .o_d_gnt(d_gnt[1]),
        .o_d_rvalid(d_rvalid[1]), .o_d_rdata(d_rdata[1]),
        .o_mem_addr(mem_addr[1]), .o_mem_we(mem_we[1]), .o_mem_wdata(mem_wdata[1]),
        .i_mem_rdata(mem_rdata1), .o_conflict_cnt(cnt1)
    );

    function automatic logic [31:0] base(input int a);
        if (a == 4)     return 32'h8C01_0100;
        if (a == 'h105) return 32'h0;
        return ((a >= 256) ? 32'h2000_0000 : 32'h1000_0000) | 32'(a);
    endfunction

    // Unit 0 memory: combinational read, write applied at the end of the grant cycle.
    assign mem_rdata0 = mem0[mem_addr[0][8:0]];
    assign mem_rdata1 = mem_addr[1] ^ 32'h5A5A_0000;

    initial begin
        logic        pw;
        logic [8:0]  pa;
        logic [31:0] pd;
        for (int i = 0; i < 512; i++) mem0[i] = base(i);
        forever begin
            @(negedge clk);
            pw = mem_we[0];
            pa = mem_addr[0][8:0];
            pd = mem_wdata[0];
            @(posedge clk);
            if (pw) mem0[pa] <= pd;
        end
    end

    function automatic logic [31:0] expdata(input int u, input logic [31:0] a);
        return (u == 0) ? ref0[a[8:0]] : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic push(input int u, input bit isd, input logic [31:0] v);
        case ({u[0], isd})
            2'b00:   qf0.push_back(v);
            2'b01:   qd0.push_back(v);
            2'b10:   qf1.push_back(v);
            default: qd1.push_back(v);
        endcase
    endtask

    task automatic chk_resp(input int u, input bit isd, input logic rv,
                            input logic [31:0] rd, input string tag);
        logic [31:0] e;
        bit          have;
        have = 1'b0;
        e    = 32'h0;
        case ({u[0], isd})
            2'b00:   if (qf0.size() > 0) begin e = qf0.pop_front(); have = 1'b1; end
            2'b01:   if (qd0.size() > 0) begin e = qd0.pop_front(); have = 1'b1; end
            2'b10:   if (qf1.size() > 0) begin e = qf1.pop_front(); have = 1'b1; end
            default: if (qd1.size() > 0) begin e = qd1.pop_front(); have = 1'b1; end
        endcase
        if (have) begin
            chk1({tag, "_rvalid"}, rv, 1'b1);
            chk32({tag, "_rdata"}, rd, e);
        end else begin
            chk1({tag, "_rvalid"}, rv, 1'b0);
        end
    endtask

    // One clock cycle: drive, check grants/memory drive mid-cycle, check response after the edge.
    task automatic cyc(input int u, input logic rst, input logic fr, input logic [31:0] fa,
                       input logic dr, input logic dw, input logic [31:0] da,
                       input logic [31:0] dwd, input logic efg, input logic edg,
                       input string tag);
        rst_n[u] = rst;  f_req[u] = fr;  f_addr[u] = fa;
        d_req[u] = dr;   d_we[u] = dw;   d_addr[u] = da;  d_wdata[u] = dwd;
        @(negedge clk);
        chk1({tag, " f_gnt"}, f_gnt[u], efg);
        chk1({tag, " d_gnt"}, d_gnt[u], edg);
        chk1({tag, " mem_we"}, mem_we[u], edg & dw);
        chk32({tag, " mem_addr"}, mem_addr[u], efg ? fa : (edg ? da : 32'h0));
        chk32({tag, " mem_wdata"}, mem_wdata[u], edg ? dwd : 32'h0);
        if (efg) push(u, 1'b0, expdata(u, fa));
        if (edg) begin
            push(u, 1'b1, expdata(u, da));
            if (u == 0 && dw) ref0[da[8:0]] = dwd;
        end
        if (!rst) cnt_exp[u] = 0;
        else if (fr && dr && cnt_exp[u] != cnt_max[u]) cnt_exp[u]++;
        @(posedge clk);
        #1;
        chk_resp(u, 1'b0, f_rvalid[u], f_rdata[u], {tag, " f"});
        chk_resp(u, 1'b1, d_rvalid[u], d_rdata[u], {tag, " d"});
        chk32({tag, " conflict_cnt"}, (u == 0) ? {16'h0, cnt0} : {30'h0, cnt1},
              32'(cnt_exp[u]));
        if (!rst) begin
            chk32({tag, " f_rdata_rst"}, f_rdata[u], 32'h0);
            chk32({tag, " d_rdata_rst"}, d_rdata[u], 32'h0);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ref0[i] = base(i);
        cnt_exp[0] = 0;      cnt_exp[1] = 0;
        cnt_max[0] = 65535;  cnt_max[1] = 3;
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0;  f_req[u] = 1'b0;  f_addr[u] = 32'h0;
            d_req[u] = 1'b0;  d_we[u] = 1'b0;   d_addr[u] = 32'h0;  d_wdata[u] = 32'h0;
        end
        @(posedge clk);
        #1;

        // Unit 0: round-robin
        cyc(0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, "rst0");
        cyc(0, 1'b1, 1'b1, 32'h004, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, "fetch");
        cyc(0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h105, 32'hDEADBEEF, 1'b0, 1'b1, "dwrite");
        cyc(0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h105, 32'h0,        1'b0, 1'b1, "dread");
        cyc(0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, "idle0");
        for (int k = 0; k < 5; k++) begin
            cyc(0, 1'b1, 1'b1, 32'h000, 1'b1, 1'b0, 32'h100, 32'h0,
                (k % 2) == 1, (k % 2) == 0, $sformatf("rr%0d", k));
        end
        cyc(0, 1'b0, 1'b1, 32'h004, 1'b1, 1'b1, 32'h105, 32'h12345678, 1'b0, 1'b0, "rst_mid");
        cyc(0, 1'b1, 1'b1, 32'h004, 1'b1, 1'b0, 32'h105, 32'h0,        1'b0, 1'b1, "post_rst");
        cyc(0, 1'b1, 1'b1, 32'h004, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, "post_rst_f");

        // Unit 1: fixed priority with starvation guard and 2-bit counter
        cyc(1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "rst1");
        for (int k = 0; k < 6; k++) begin
            cyc(1, 1'b1, 1'b1, 32'h040, 1'b1, 1'b0, 32'h140, 32'h0,
                (k % 3) == 2, (k % 3) != 2, $sformatf("prio%0d", k));
        end
        cyc(1, 1'b1, 1'b1, 32'h044, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "lone_f1");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
